// File: rtl/mem_pkg.sv
// Request/response types shared by the memory front-end and its SRAM banks.
package mem_pkg;

  parameter int unsigned MEM_AW = 32;
  parameter int unsigned MEM_DW = 32;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [MEM_AW-1:0]     addr;
    logic [MEM_DW-1:0]     data;
    logic [MEM_DW/8-1:0]   mask;
  } mem_h2d_t;

  typedef struct packed {
    logic              gnt;
    logic [MEM_DW-1:0] data;
    logic              valid;
    logic [1:0]        error;
  } mem_d2h_t;

endpackage

// File: rtl/mem_sram_bank.sv
// Word-addressed single-port SRAM bank with programmable grant wait states and
// a pipelined read return. ReadOnly=1 turns it into a ROM leg.
module mem_sram_bank
  import mem_pkg::*;
#(
  parameter int unsigned Depth       = 16384,
  parameter int unsigned ReadLatency = 1,
  parameter int unsigned WaitStates  = 0,
  parameter bit          ReadOnly    = 1'b0,
  parameter string       InitFile    = ""
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  mem_h2d_t mem_i,
  output mem_d2h_t mem_o
);

  localparam int unsigned IdxW     = (Depth > 1) ? $clog2(Depth) : 1;
  // The IDLE cycle in which req rises already counts as one wait state.
  localparam int unsigned WaitInit = (WaitStates > 1) ? WaitStates - 2 : 0;

  typedef enum logic [1:0] {StIdle, StWait, StGrant} state_e;

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               gnt;
  logic               accept;
  logic               in_range;
  logic [IdxW-1:0]    idx;

  logic [MEM_DW-1:0]      mem_q [Depth];
  logic [ReadLatency-1:0] vld_q;
  logic [ReadLatency-1:0] err_q;
  logic [MEM_DW-1:0]      rdata_q [ReadLatency];

  assign idx      = mem_i.addr[IdxW-1:0];
  assign in_range = mem_i.addr < MEM_AW'(Depth);
  assign accept   = mem_i.req && gnt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    case (state_q)
      StIdle: begin
        if (WaitStates == 0) begin
          gnt = mem_i.req;
        end else if (mem_i.req) begin
          if (WaitStates == 1) begin
            state_d = StGrant;
          end else begin
            state_d = StWait;
            cnt_d   = 3'(WaitInit);
          end
        end
      end
      StWait: begin
        if (!mem_i.req) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StGrant;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StGrant: begin
        gnt     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Nothing is granted (and so nothing is written) while reset is held.
    if (!rst_ni) begin
      gnt     = 1'b0;
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage is deliberately outside reset so contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (accept && mem_i.we && in_range && !ReadOnly) begin
      for (int i = 0; i < MEM_DW / 8; i++) begin
        if (mem_i.mask[i]) begin
          mem_q[idx][8*i +: 8] <= mem_i.data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < ReadLatency; i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      vld_q[0]   <= accept && !mem_i.we;
      err_q[0]   <= !in_range;
      rdata_q[0] <= in_range ? mem_q[idx] : '0;
      for (int i = 1; i < ReadLatency; i++) begin
        vld_q[i]   <= vld_q[i-1];
        err_q[i]   <= err_q[i-1];
        rdata_q[i] <= rdata_q[i-1];
      end
    end
  end

  always_comb begin
    mem_o     = '0;
    mem_o.gnt = gnt;
    if (vld_q[ReadLatency-1]) begin
      mem_o.valid = 1'b1;
      mem_o.data  = rdata_q[ReadLatency-1];
      mem_o.error = {err_q[ReadLatency-1], 1'b0};
    end
  end

  ParamRange_A: assert property (@(posedge clk_i)
    ReadLatency >= 1 && ReadLatency <= 4 && WaitStates <= 7);

  ReqStable_A: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_i.req && !mem_o.gnt |=> $stable({mem_i.we, mem_i.addr, mem_i.data, mem_i.mask}));

  WaitHoldsReq_A: assert property (@(posedge clk_i) disable iff (!rst_ni)
    state_q == StWait |-> mem_i.req);

  NoXOut_A: assert property (@(posedge clk_i)
    rst_ni |-> !$isunknown({mem_o.gnt, mem_o.valid}));

endmodule

// File: tb/tb_mem_sram_bank.sv
// Bench for mem_sram_bank: directed scenarios on four configurations plus
// randomized traffic checked against an array/queue reference model.
module tb_mem_sram_bank;
  import mem_pkg::*;

  localparam int NumDut = 4;

  typedef struct packed {
    int          due;
    logic [31:0] data;
    logic [1:0]  err;
  } exp_t;

  logic     clk = 1'b0;
  logic     rst_n;
  mem_h2d_t h2d [NumDut];
  mem_d2h_t d2h [NumDut];

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] ref_mem [NumDut][256];

  always #5 clk = ~clk;

  mem_sram_bank #(.Depth(16384), .ReadLatency(1), .WaitStates(0)) u_ram (
    .clk_i(clk), .rst_ni(rst_n), .mem_i(h2d[0]), .mem_o(d2h[0]));
  mem_sram_bank #(.Depth(256), .ReadLatency(3), .WaitStates(0)) u_pipe (
    .clk_i(clk), .rst_ni(rst_n), .mem_i(h2d[1]), .mem_o(d2h[1]));
  mem_sram_bank #(.Depth(256), .ReadLatency(2), .WaitStates(2)) u_wait (
    .clk_i(clk), .rst_ni(rst_n), .mem_i(h2d[2]), .mem_o(d2h[2]));
  mem_sram_bank #(.Depth(256), .ReadLatency(1), .WaitStates(1), .ReadOnly(1'b1)) u_rom (
    .clk_i(clk), .rst_ni(rst_n), .mem_i(h2d[3]), .mem_o(d2h[3]));

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic drive(input int k, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] mask);
    h2d[k] = '{req: req, we: we, addr: addr, data: data, mask: mask};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < NumDut; k++) drive(k, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'd5, 32'h0BAD_0BAD, 4'hf);
    #1;
    vectors++;
    if (d2h[0].gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_gnt_in_reset: got %b want 0", d2h[0].gnt);
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < NumDut; k++) begin
      vectors++;
      if (d2h[k] !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs dut%0d: got gnt=%b valid=%b data=%h err=%b want all 0",
                 k, d2h[k].gnt, d2h[k].valid, d2h[k].data, d2h[k].error);
      end
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF, 4'hf);
    #1;
    vectors++;
    if (d2h[0].gnt !== 1'b1) begin
      miscompares++; $display("FAIL wr_gnt: got %b want 1", d2h[0].gnt);
    end
    ref_mem[0][5] = 32'hDEAD_BEEF;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'd5, '0, '0);
    #1;
    vectors++;
    if (d2h[0].gnt !== 1'b1 || d2h[0].valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_gnt_no_wr_valid: got gnt=%b valid=%b want gnt=1 valid=0",
               d2h[0].gnt, d2h[0].valid);
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    vectors++;
    if (d2h[0].valid !== 1'b1 || d2h[0].data !== ref_mem[0][5] || d2h[0].error !== 2'b00) begin
      miscompares++;
      $display("FAIL raw_read: got valid=%b data=%h err=%b want 1 %h 00",
               d2h[0].valid, d2h[0].data, d2h[0].error, ref_mem[0][5]);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (d2h[0].valid !== 1'b0 || d2h[0].data !== 32'h0) begin
      miscompares++;
      $display("FAIL valid_one_cycle: got valid=%b data=%h want 0 0", d2h[0].valid, d2h[0].data);
    end
  endtask

  task automatic test_partial_mask();
    logic [31:0] exp_d;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'd7, 32'hAABB_CCDD, 4'hf);
    ref_mem[0][7] = 32'hAABB_CCDD;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'd7, 32'h1122_3344, 4'b0101);
    ref_mem[0][7] = merge(ref_mem[0][7], 32'h1122_3344, 4'b0101);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'd7, '0, '0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    exp_d = ref_mem[0][7];
    vectors++;
    if (d2h[0].valid !== 1'b1 || d2h[0].data !== exp_d || exp_d !== 32'hAA22_CC44) begin
      miscompares++;
      $display("FAIL partial_mask: got valid=%b data=%h want 1 %h", d2h[0].valid, d2h[0].data,
               exp_d);
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_v;
    logic [31:0] exp_d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ref_mem[1][i] = $urandom;
      drive(1, 1'b1, 1'b1, 32'(i), ref_mem[1][i], 4'hf);
    end
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (j < 4) drive(1, 1'b1, 1'b0, 32'(j), '0, '0);
      else drive(1, 1'b0, 1'b0, '0, '0, '0);
      #1;
      exp_v = (j >= 3 && j <= 6);
      exp_d = exp_v ? ref_mem[1][j-3] : 32'h0;
      vectors++;
      if (d2h[1].gnt !== (j < 4) || d2h[1].valid !== exp_v || d2h[1].data !== exp_d) begin
        miscompares++;
        $display("FAIL b2b_cycle%0d: got gnt=%b valid=%b data=%h want gnt=%b valid=%b data=%h",
                 j, d2h[1].gnt, d2h[1].valid, d2h[1].data, j < 4, exp_v, exp_d);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] wdata;
    logic        exp_g;
    logic        exp_v;
    wdata = $urandom;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c < 3) drive(2, 1'b1, 1'b1, 32'd9, wdata, 4'hf);
      else if (c < 6) drive(2, 1'b1, 1'b0, 32'd9, '0, '0);
      else drive(2, 1'b0, 1'b0, '0, '0, '0);
      #1;
      exp_g = (c == 2 || c == 5);
      exp_v = (c == 7);
      vectors++;
      if (d2h[2].gnt !== exp_g || d2h[2].valid !== exp_v ||
          d2h[2].data !== (exp_v ? wdata : 32'h0)) begin
        miscompares++;
        $display("FAIL wait2_cycle%0d: got gnt=%b valid=%b data=%h want gnt=%b valid=%b data=%h",
                 c, d2h[2].gnt, d2h[2].valid, d2h[2].data, exp_g, exp_v,
                 exp_v ? wdata : 32'h0);
      end
    end
    ref_mem[2][9] = wdata;
    // ROM leg, one wait state: write is granted then discarded.
    wdata = $urandom;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 2) drive(3, 1'b1, 1'b1, 32'd4, wdata, 4'hf);
      else if (c < 4) drive(3, 1'b1, 1'b0, 32'd4, '0, '0);
      else drive(3, 1'b0, 1'b0, '0, '0, '0);
      #1;
      exp_g = (c == 1 || c == 3);
      exp_v = (c == 4);
      vectors++;
      if (d2h[3].gnt !== exp_g || d2h[3].valid !== exp_v || d2h[3].error !== 2'b00 ||
          (exp_v && d2h[3].data === wdata)) begin
        miscompares++;
        $display("FAIL rom_cycle%0d: got gnt=%b valid=%b data=%h want gnt=%b valid=%b data!=%h",
                 c, d2h[3].gnt, d2h[3].valid, d2h[3].data, exp_g, exp_v, wdata);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic        op_we   [6];
    logic [31:0] op_addr [6];
    logic [31:0] op_data [6];
    logic        pend_v;
    logic [31:0] pend_d;
    logic [1:0]  pend_e;
    logic [31:0] w0;
    w0 = $urandom;
    op_we[0] = 1'b1; op_addr[0] = 32'd0;         op_data[0] = w0;
    op_we[1] = 1'b0; op_addr[1] = 32'd16384;     op_data[1] = '0;
    op_we[2] = 1'b1; op_addr[2] = 32'd16384;     op_data[2] = ~w0;
    op_we[3] = 1'b0; op_addr[3] = 32'd0;         op_data[3] = '0;
    op_we[4] = 1'b0; op_addr[4] = 32'h0010_0005; op_data[4] = '0;
    op_we[5] = 1'b0; op_addr[5] = 32'd0;         op_data[5] = '0;
    pend_v = 1'b0; pend_d = '0; pend_e = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(0, c < 5, op_we[c], op_addr[c], op_data[c], 4'hf);
      #1;
      vectors++;
      if (d2h[0].valid !== pend_v || d2h[0].data !== pend_d || d2h[0].error !== pend_e) begin
        miscompares++;
        $display("FAIL oor_cycle%0d: got valid=%b data=%h err=%b want %b %h %b",
                 c, d2h[0].valid, d2h[0].data, d2h[0].error, pend_v, pend_d, pend_e);
      end
      pend_v = 1'b0; pend_d = '0; pend_e = '0;
      if (c < 5) begin
        if (op_we[c]) begin
          if (op_addr[c] < 32'd16384) ref_mem[0][op_addr[c][7:0]] = op_data[c];
        end else begin
          pend_v = 1'b1;
          pend_d = (op_addr[c] < 32'd16384) ? ref_mem[0][op_addr[c][7:0]] : 32'h0;
          pend_e = (op_addr[c] < 32'd16384) ? 2'b00 : 2'b10;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    logic        exp_g;
    logic        exp_v;
    v = $urandom;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      rst_n = !(c == 6 || c == 7);
      if (c < 3) drive(2, 1'b1, 1'b1, 32'd3, v, 4'hf);
      else if (c < 6 || (c >= 9 && c < 12)) drive(2, 1'b1, 1'b0, 32'd3, '0, '0);
      else drive(2, 1'b0, 1'b0, '0, '0, '0);
      #1;
      exp_g = (c == 2 || c == 5 || c == 11);
      exp_v = (c == 13);
      vectors++;
      if (d2h[2].gnt !== exp_g || d2h[2].valid !== exp_v ||
          d2h[2].data !== (exp_v ? v : 32'h0)) begin
        miscompares++;
        $display("FAIL rst_mid_cycle%0d: got gnt=%b valid=%b data=%h want gnt=%b valid=%b data=%h",
                 c, d2h[2].gnt, d2h[2].valid, d2h[2].data, exp_g, exp_v, exp_v ? v : 32'h0);
      end
    end
    ref_mem[2][3] = v;
  endtask

  task automatic test_random(input int k, input int lat, input int unsigned depth, input int n);
    exp_t        expq [$];
    logic        req, we, exp_v, in_rng;
    logic [31:0] addr, data, exp_d;
    logic [3:0]  mask;
    logic [1:0]  exp_e;
    for (int c = 0; c < n + lat + 2; c++) begin
      @(negedge clk);
      req = 1'b0; we = 1'b0; addr = '0; data = '0; mask = '0;
      if (c < 16) begin
        req = 1'b1; we = 1'b1; addr = 32'(c); data = $urandom; mask = 4'hf;
      end else if (c < n && $urandom_range(0, 3) != 0) begin
        req  = 1'b1;
        we   = 1'($urandom_range(0, 1));
        data = $urandom;
        mask = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 9))
          0:       addr = depth + 32'($urandom_range(0, 3));
          1:       addr = 32'h8000_0000 | 32'($urandom_range(0, 15));
          default: addr = 32'($urandom_range(0, 15));
        endcase
      end
      drive(k, req, we, addr, data, mask);
      #1;
      vectors++;
      if (d2h[k].gnt !== req) begin
        miscompares++;
        $display("FAIL rand%0d_gnt cycle%0d: got %b want %b", k, c, d2h[k].gnt, req);
      end
      exp_v = (expq.size() > 0) && (expq[0].due == c);
      exp_d = exp_v ? expq[0].data : 32'h0;
      exp_e = exp_v ? expq[0].err : 2'b00;
      vectors++;
      if (d2h[k].valid !== exp_v || d2h[k].data !== exp_d || d2h[k].error !== exp_e) begin
        miscompares++;
        $display("FAIL rand%0d_resp cycle%0d: got valid=%b data=%h err=%b want %b %h %b",
                 k, c, d2h[k].valid, d2h[k].data, d2h[k].error, exp_v, exp_d, exp_e);
      end
      if (exp_v) void'(expq.pop_front());
      if (req) begin
        in_rng = addr < depth;
        if (we) begin
          if (in_rng) ref_mem[k][addr[7:0]] = merge(ref_mem[k][addr[7:0]], data, mask);
        end else begin
          expq.push_back('{due: c + lat, data: in_rng ? ref_mem[k][addr[7:0]] : 32'h0,
                           err: in_rng ? 2'b00 : 2'b10});
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NumDut; k++) drive(k, 1'b0, 1'b0, '0, '0, '0);
    test_reset();
    test_write_read();
    test_partial_mask();
    test_back_to_back();
    test_wait_states();
    test_out_of_range();
    test_reset_mid();
    test_random(0, 1, 16384, 300);
    test_random(1, 3, 256, 300);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "timeout");
  end

endmodule
